// File: rtl/uart_word_assembler_pkg.sv
// Shared definitions for the UART word assembler: receiver state encoding
// and default timing constants (25 MHz clock, 115200 baud).
package uart_word_assembler_pkg;

  localparam int DEF_CLKS_PER_BIT = 217;
  localparam int DEF_TIMEOUT_CLKS = 4340;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_byte_deser.sv
// 8N1 byte deserializer with a 2-flop input synchronizer.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | line idle, waiting for a low level (start bit)
//   ST_START | counting to mid start bit; high there = glitch, drop it
//   ST_DATA  | sampling 8 data bits LSB-first, one bit period apart
//   ST_STOP  | sampling the stop bit; low = framing error
//   ST_BREAK | after a framing error, wait for the line to return high
//
// byte_valid_o / frame_err_o / start_o are combinational and only asserted
// in the clock of the deciding sample; the top registers them.
module uart_byte_deser
  import uart_word_assembler_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       CLK_25MHZ,
  input  logic       RSTN,
  input  logic       RXD,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o,
  output logic       start_o,
  output logic       idle_o
);

  localparam int            CW      = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF    = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic          rxd_meta_q, rxd_sync_q;
  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;

  // Synchronizer, state register and datapath registers.
  always_ff @(posedge CLK_25MHZ or posedge RSTN) begin
    if (RSTN) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
    end else begin
      rxd_meta_q <= RXD;
      rxd_sync_q <= rxd_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
    end
  end

  // Next-state, bit timing and sampling decisions.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_o = 1'b0;
    frame_err_o  = 1'b0;
    start_o      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxd_sync_q) begin
          state_d   = ST_START;
          cnt_d     = '0;
          bit_idx_d = '0;
          start_o   = 1'b1;
        end
      end
      ST_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = rxd_sync_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          shift_d   = {rxd_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxd_sync_q) begin
            byte_valid_o = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            frame_err_o = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BREAK: begin
        if (rxd_sync_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign byte_data_o = shift_q;
  assign idle_o      = (state_q == ST_IDLE);

endmodule

// File: rtl/uart_word_assembler.sv
// Assembles four UART bytes (first byte least significant) into a 32-bit
// word; discards a partial word after an inter-byte idle timeout.
module uart_word_assembler
  import uart_word_assembler_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
  input  logic        CLK_25MHZ,
  input  logic        RSTN,
  input  logic        RXD,
  output logic        o_Rx_DV,
  output logic [31:0] o_Rx_Four_Bytes,
  output logic        o_Frame_Err,
  output logic        o_Timeout
);

  localparam int            IW      = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [IW-1:0] TMO_MAX = IW'(TIMEOUT_CLKS);

  logic          byte_valid, frame_err, start_det, deser_idle;
  logic [7:0]    byte_data;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   asm_q, asm_d;
  logic [31:0]   word_q, word_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          dv_q, dv_d, ferr_q, ferr_d, tmo_q, tmo_d;
  logic          idle_run;

  uart_byte_deser #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_deser (
    .CLK_25MHZ    (CLK_25MHZ),
    .RSTN         (RSTN),
    .RXD          (RXD),
    .byte_valid_o (byte_valid),
    .byte_data_o  (byte_data),
    .frame_err_o  (frame_err),
    .start_o      (start_det),
    .idle_o       (deser_idle)
  );

  // Word assembly, idle timeout and output pulse registers.
  always_ff @(posedge CLK_25MHZ or posedge RSTN) begin
    if (RSTN) begin
      byte_idx_q <= '0;
      asm_q      <= '0;
      word_q     <= '0;
      idle_cnt_q <= '0;
      dv_q       <= 1'b0;
      ferr_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      word_q     <= word_d;
      idle_cnt_q <= idle_cnt_d;
      dv_q       <= dv_d;
      ferr_q     <= ferr_d;
      tmo_q      <= tmo_d;
    end
  end

  // Byte placement, word completion and timeout decisions.
  always_comb begin
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    word_d     = word_q;
    idle_cnt_d = idle_cnt_q;
    dv_d       = 1'b0;
    ferr_d     = 1'b0;
    tmo_d      = 1'b0;
    idle_run   = deser_idle && (byte_idx_q != 2'd0);

    if (start_det) begin
      idle_cnt_d = '0;
    end else if (idle_run && (idle_cnt_q != TMO_MAX)) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end

    // A timeout can only fire while the deserializer is idle, so it never
    // coincides with a byte or framing decision. A start bit detected in
    // the same clock simply begins the next word at index 0.
    if (idle_run && (idle_cnt_q == TMO_MAX - 1'b1)) begin
      tmo_d      = 1'b1;
      byte_idx_d = '0;
      asm_d      = '0;
    end else if (frame_err) begin
      ferr_d     = 1'b1;
      byte_idx_d = '0;
      asm_d      = '0;
    end else if (byte_valid) begin
      asm_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
      byte_idx_d = byte_idx_q + 2'd1;
      if (byte_idx_q == 2'd3) begin
        word_d = {byte_data, asm_q[23:0]};
        dv_d   = 1'b1;
      end
    end
  end

  assign o_Rx_DV         = dv_q;
  assign o_Rx_Four_Bytes = word_q;
  assign o_Frame_Err     = ferr_q;
  assign o_Timeout       = tmo_q;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Scoreboard bench for uart_word_assembler: a byte-level reference model
// queues expected events (word, framing error, timeout); a monitor pops
// and compares whenever the DUT raises a flag.
module tb_uart_word_assembler;

  localparam int CPB = 217;
  localparam int TMO = 4340;

  logic        CLK_25MHZ = 1'b0;
  logic        RSTN      = 1'b1;
  logic        RXD       = 1'b1;
  logic        o_Rx_DV, o_Frame_Err, o_Timeout;
  logic [31:0] o_Rx_Four_Bytes;

  uart_word_assembler #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .CLK_25MHZ       (CLK_25MHZ),
    .RSTN            (RSTN),
    .RXD             (RXD),
    .o_Rx_DV         (o_Rx_DV),
    .o_Rx_Four_Bytes (o_Rx_Four_Bytes),
    .o_Frame_Err     (o_Frame_Err),
    .o_Timeout       (o_Timeout)
  );

  always #20 CLK_25MHZ = ~CLK_25MHZ;

  typedef enum int {EV_WORD = 0, EV_FERR = 1, EV_TMO = 2} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [31:0] word;
  } ev_t;

  ev_t         exp_q[$];
  logic [7:0]  part_q[$];
  logic [31:0] model_word = 32'h0;
  int          checks   = 0;
  int          failures = 0;

  // ---------------- reference model ----------------
  function automatic void push_ev(input ev_kind_t k, input logic [31:0] w);
    ev_t e;
    e.kind = k;
    e.word = w;
    exp_q.push_back(e);
  endfunction

  function automatic void model_byte_ok(input logic [7:0] b);
    logic [31:0] w;
    part_q.push_back(b);
    if (part_q.size() == 4) begin
      w = 32'h0;
      for (int i = 0; i < 4; i++) w = w + (32'(part_q[i]) << (8 * i));
      model_word = w;
      push_ev(EV_WORD, w);
      part_q.delete();
    end
  endfunction

  function automatic void model_frame_err();
    push_ev(EV_FERR, 32'h0);
    part_q.delete();
  endfunction

  function automatic void model_idle(input int gap);
    if (gap >= TMO && part_q.size() > 0) begin
      push_ev(EV_TMO, 32'h0);
      part_q.delete();
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge CLK_25MHZ);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int period);
    RXD = 1'b0;
    wait_clks(period);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      wait_clks(period);
    end
    RXD = stop_ok;
    wait_clks(period);
  endtask

  task automatic send_byte(input logic [7:0] b, input int period);
    model_byte_ok(b);
    send_frame(b, 1'b1, period);
  endtask

  task automatic send_bad(input logic [7:0] b);
    model_frame_err();
    send_frame(b, 1'b0, CPB);
  endtask

  task automatic idle(input int gap);
    model_idle(gap);
    RXD = 1'b1;
    wait_clks(gap);
  endtask

  task automatic check_drain(input string name);
    wait_clks(8);
    chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_word"}, 64'(o_Rx_Four_Bytes), 64'(model_word));
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    ev_t e;
    ev_kind_t got;
    forever begin
      @(negedge CLK_25MHZ);
      if (o_Rx_DV || o_Frame_Err || o_Timeout) begin
        checks++;
        got = o_Rx_DV ? EV_WORD : (o_Frame_Err ? EV_FERR : EV_TMO);
        if ($countones({o_Rx_DV, o_Frame_Err, o_Timeout}) > 1) begin
          failures++;
          $display("FAIL flags_exclusive: got dv=%0b ferr=%0b tmo=%0b expected one flag",
                   o_Rx_DV, o_Frame_Err, o_Timeout);
        end else if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event: got kind %0d expected none", int'(got));
        end else begin
          e = exp_q.pop_front();
          if (got != e.kind) begin
            failures++;
            $display("FAIL event_kind: got %0d expected %0d", int'(got), int'(e.kind));
          end else if (got == EV_WORD && o_Rx_Four_Bytes !== e.word) begin
            failures++;
            $display("FAIL word_value: got %08h expected %08h", o_Rx_Four_Bytes, e.word);
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #(64'd6_000_000);
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [7:0] rb;
    logic [7:0] third;
    RSTN = 1'b1;
    RXD  = 1'b1;
    wait_clks(5);
    chk("reset_outputs", 64'({o_Rx_DV, o_Frame_Err, o_Timeout, o_Rx_Four_Bytes}), 64'd0);
    RSTN = 1'b0;
    wait_clks(10);

    // back-to-back word
    send_byte(8'h78, CPB);
    send_byte(8'h56, CPB);
    send_byte(8'h34, CPB);
    send_byte(8'h12, CPB);
    check_drain("word_12345678");

    // partial word discarded by idle timeout
    send_byte(8'hAA, CPB);
    send_byte(8'hBB, CPB);
    idle(TMO);
    check_drain("timeout");
    send_byte(8'h01, CPB);
    send_byte(8'h00, CPB);
    send_byte(8'h00, CPB);
    send_byte(8'h00, CPB);
    check_drain("word_00000001");

    // framing error followed by a long break
    send_bad(8'h55);
    wait_clks(2000);
    RXD = 1'b1;
    wait_clks(CPB);
    check_drain("frame_err_break");

    // glitch between bytes must not disturb the byte index
    send_byte(8'h11, CPB);
    RXD = 1'b0;
    wait_clks(50);
    RXD = 1'b1;
    wait_clks(CPB);
    send_byte(8'h22, CPB);
    send_byte(8'h33, CPB);
    send_byte(8'h44, CPB);
    check_drain("glitch_word");

    // reset during bit 4 of the third byte
    send_byte(8'hC3, CPB);
    send_byte(8'h3C, CPB);
    third = 8'hA5;
    RXD = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 4; i++) begin
      RXD = third[i];
      wait_clks(CPB);
    end
    RXD = third[4];
    wait_clks(CPB / 2);
    RSTN = 1'b1;
    exp_q.delete();
    part_q.delete();
    model_word = 32'h0;
    #1;
    chk("midframe_reset_outputs",
        64'({o_Rx_DV, o_Frame_Err, o_Timeout, o_Rx_Four_Bytes}), 64'd0);
    RXD = 1'b1;
    wait_clks(20);
    RSTN = 1'b0;
    wait_clks(3 * CPB);
    check_drain("after_reset");

    // random clean traffic with short random gaps
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_byte(rb, CPB);
      idle($urandom_range(0, 400));
    end
    check_drain("random_words");

    // +/-2% skewed bit timing
    send_byte(8'hEF, 221);
    send_byte(8'hBE, 213);
    send_byte(8'hAD, 221);
    send_byte(8'hDE, 213);
    check_drain("skew_deadbeef");
    chk("skew_word_const", 64'(o_Rx_Four_Bytes), 64'h0000_0000_DEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_word_assembler.md
UART_WORD_ASSEMBLER -- requirements
Module: uart_word_assembler

Interface
REQ-001 Parameter CLKS_PER_BIT, default 217, SHALL set the clocks per UART bit (115200 baud at 25 MHz).
REQ-002 Parameter TIMEOUT_CLKS, default 4340, SHALL set the inter-byte idle limit in clocks.
REQ-003 CLK_25MHZ  input  1  SHALL be the sole clock; all logic rising-edge.
REQ-004 RSTN  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 RXD  input  1  SHALL carry asynchronous serial data (8N1, idle high, LSB-first bits).
REQ-006 o_Rx_DV  output  1  SHALL pulse high for one clock when a complete 32-bit word is valid.
REQ-007 o_Rx_Four_Bytes  output  32  SHALL carry the last completed word.
REQ-008 o_Frame_Err  output  1  SHALL pulse high for one clock on a stop-bit error.
REQ-009 o_Timeout  output  1  SHALL pulse high for one clock when a partial word is discarded on timeout.

Function
REQ-010 RXD SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-012 IDLE: synchronized RXD low -> START, bit counter cleared.
REQ-013 START: at count CLKS_PER_BIT/2 (integer division), RXD low -> DATA; RXD high -> IDLE (glitch rejected, no flag).
REQ-014 DATA: each bit sampled CLKS_PER_BIT clocks after the previous sample, shifted LSB-first; after bit 7 -> STOP.
REQ-015 STOP: sampled CLKS_PER_BIT clocks after bit 7; high -> byte accepted, IDLE; low -> o_Frame_Err pulse, partial word and byte index cleared, BREAK.
REQ-016 BREAK: remain until synchronized RXD high, then IDLE.
REQ-017 Accepted byte n (index 0..3) SHALL load bits [8n+7:8n] of the assembly register; first byte is least significant.
REQ-018 On acceptance of byte index 3, o_Rx_Four_Bytes SHALL update and o_Rx_DV SHALL pulse in the clock after the stop-bit sample; byte index wraps to 0.
REQ-019 o_Rx_Four_Bytes SHALL hold its value between o_Rx_DV pulses and not change on partial bytes, errors or timeouts.
REQ-020 Idle counter SHALL run only in IDLE with byte index nonzero, clear on every START entry, saturate at TIMEOUT_CLKS.
REQ-021 Idle counter reaching TIMEOUT_CLKS SHALL pulse o_Timeout once, clear byte index and assembly register.
REQ-022 Timeout and start-bit detection in the same clock: timeout wins, the start bit begins byte index 0.
REQ-023 With byte index 0, no timeout SHALL ever fire.
REQ-024 o_Rx_DV, o_Frame_Err, o_Timeout SHALL be mutually exclusive in any clock.
REQ-025 Bit-timing counter width SHALL be ceil(log2(CLKS_PER_BIT+1)); idle counter width ceil(log2(TIMEOUT_CLKS+1)).

Reset
REQ-026 RSTN high SHALL force: FSM IDLE, synchronizer flops 1, all counters 0, byte index 0, assembly register 0, o_Rx_Four_Bytes 32'h0, o_Rx_DV/o_Frame_Err/o_Timeout 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after release, a frame in progress SHALL be rejected or resynchronized on the next falling edge, never producing o_Rx_DV from partial data.

Structure
REQ-028 Shared package SHALL hold the FSM state encoding, default CLKS_PER_BIT (217) and TIMEOUT_CLKS (4340) constants.
REQ-029 Byte-level deserializer (REQ-010..016) SHALL be sub-module uart_byte_deser with byte-valid and frame-error outputs; the top holds byte index, assembly register and timeout.

Verification
REQ-030 Bytes 0x78,0x56,0x34,0x12 back-to-back at 217 clk/bit -> one o_Rx_DV pulse, o_Rx_Four_Bytes = 32'h12345678.
REQ-031 Two bytes 0xAA,0xBB then 4340 idle clocks -> o_Timeout pulse once; next four bytes 0x01,0x00,0x00,0x00 -> word 32'h00000001.
REQ-032 Byte 0x55 with stop bit low -> o_Frame_Err pulse, no o_Rx_DV; RXD held low 2000 clocks then high -> no further flags; next full word received correctly.
REQ-033 50-clock low glitch on idle RXD -> no byte accepted, no flags, byte index unchanged.
REQ-034 RSTN asserted during bit 4 of the third byte -> all outputs 0 within one clock; subsequent clean 4-byte frame yields correct word.
REQ-035 Bit timing skewed +/-2% on a 4-byte word 32'hDEADBEEF -> word received correctly.
